// File: rtl/lockstep_equiv_checker.sv
// lockstep_equiv_checker: LFSR stimulus generator and lockstep output comparator; define CONTINUE_ON_FAIL_EN to run all vectors instead of aborting on the first mismatch
module lockstep_equiv_checker #(
  parameter int          IN_W        = 2,
  parameter int          OUT_W       = 1,
  parameter int          LATENCY     = 2,
  parameter int          II          = 2,
  parameter int          NUM_VECTORS = 16,
  parameter logic [31:0] SEED        = 32'h1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [IN_W-1:0]   stim,
  input  logic [OUT_W-1:0]  dut_out,
  input  logic [OUT_W-1:0]  ref_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic [15:0]       mismatch_count,
  output logic [15:0]       first_fail_index,
  output logic [OUT_W-1:0]  first_fail_dut,
  output logic [OUT_W-1:0]  first_fail_ref
);
  localparam logic [31:0] TAPS  = 32'h80200003;
  localparam logic [31:0] SEED0 = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam int          HW    = (II > 1) ? $clog2(II) : 1;
  localparam logic [15:0] LAST  = 16'(NUM_VECTORS - 1);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [31:0] lfsr, lfsr_step;
  logic [HW-1:0] hold;
  logic [15:0] vec_idx;
  logic [LATENCY-1:0] pv;
  logic [15:0] pidx [LATENCY];
  logic start_q, go, issue, last_hold, cmp_v, mism, fin, abort;
  assign lfsr_step = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? TAPS : 32'h0);
  assign go        = start && !start_q && (state == IDLE || state == DONE);
  assign last_hold = hold == HW'(II - 1);
  assign issue     = state == RUN && hold == '0;
  assign cmp_v     = pv[LATENCY-1] && busy;
  assign mism      = cmp_v && (dut_out !== ref_out);
  assign fin       = cmp_v && pidx[LATENCY-1] == LAST;
`ifdef CONTINUE_ON_FAIL_EN
  assign abort = 1'b0;
`else
  assign abort = mism;
`endif
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end
  // next state: a finishing or aborting compare wins over the RUN->DRAIN hand-off
  always_comb begin
    busy = state == RUN || state == DRAIN;
    state_nx = state;
    if (go) state_nx = RUN;
    else if (busy && (abort || fin)) state_nx = DONE;
    else if (state == RUN && last_hold && vec_idx == LAST) state_nx = DRAIN;
  end
  // stimulus generation, compare pipeline and result capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_q <= 1'b0;
      lfsr <= SEED0;
      stim <= '0;
      hold <= '0;
      vec_idx <= '0;
      pv <= '0;
      for (int k = 0; k < LATENCY; k++) pidx[k] <= '0;
      done <= 1'b0;
      pass <= 1'b0;
      fail <= 1'b0;
      mismatch_count <= '0;
      first_fail_index <= '0;
      first_fail_dut <= '0;
      first_fail_ref <= '0;
    end else begin
      start_q <= start;
      for (int k = LATENCY - 1; k > 0; k--) begin
        pv[k] <= pv[k-1];
        pidx[k] <= pidx[k-1];
      end
      pv[0] <= issue;
      pidx[0] <= vec_idx;
      if (go) begin
        pv <= '0;
        lfsr <= SEED0;
        stim <= SEED0[IN_W-1:0];
        hold <= '0;
        vec_idx <= '0;
        done <= 1'b0;
        pass <= 1'b0;
        fail <= 1'b0;
        mismatch_count <= '0;
        first_fail_index <= '0;
        first_fail_dut <= '0;
        first_fail_ref <= '0;
      end else begin
        if (abort) pv <= '0;
        if (state == RUN && !abort && !fin) begin
          hold <= last_hold ? '0 : hold + HW'(1);
          if (last_hold && vec_idx != LAST) begin
            vec_idx <= vec_idx + 16'd1;
            lfsr <= lfsr_step;
            stim <= lfsr_step[IN_W-1:0];
          end
        end
        if (mism) begin
          mismatch_count <= (mismatch_count == 16'hFFFF) ? mismatch_count : mismatch_count + 16'd1;
          if (!fail) begin
            fail <= 1'b1;
            first_fail_index <= pidx[LATENCY-1];
            first_fail_dut <= dut_out;
            first_fail_ref <= ref_out;
          end
        end
        if (busy && (abort || fin)) begin
          done <= 1'b1;
          pass <= !(fail || mism);
        end
      end
    end
  end
endmodule

// File: tb/tb_lockstep_equiv_checker.sv
// tb_lockstep_equiv_checker: directed table and sequence checks of the lockstep checker
module tb_lockstep_equiv_checker;
  logic clk = 1'b0, rst = 1'b1, start_a = 1'b0, start_b = 1'b0, mode = 1'b0;
  logic [1:0] stim_a, stim_b;
  logic dut_a, ref_a, r1, r2;
  logic busy_a, done_a, pass_a, fail_a, ffd_a, ffr_a;
  logic [15:0] cnt_a, ffi_a;
  logic busy_b, done_b, pass_b, fail_b, ffd_b, ffr_b;
  logic [15:0] cnt_b, ffi_b;
  int n_cmp = 0, n_err = 0, e = 0;
  always #5 clk = ~clk;
  // equivalent pair: two-stage registered a&b
  always_ff @(posedge clk) begin
    r1 <= stim_a[1] & stim_a[0];
    r2 <= r1;
  end
  assign dut_a = mode ? 1'b0 : r2;
  assign ref_a = mode ? 1'b1 : r2;
  lockstep_equiv_checker u_a (
    .clk(clk), .rst(rst), .start(start_a), .stim(stim_a), .dut_out(dut_a), .ref_out(ref_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .fail(fail_a), .mismatch_count(cnt_a),
    .first_fail_index(ffi_a), .first_fail_dut(ffd_a), .first_fail_ref(ffr_a));
  lockstep_equiv_checker #(.II(3)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .stim(stim_b), .dut_out(1'b0), .ref_out(1'b0),
    .busy(busy_b), .done(done_b), .pass(pass_b), .fail(fail_b), .mismatch_count(cnt_b),
    .first_fail_index(ffi_b), .first_fail_dut(ffd_b), .first_fail_ref(ffr_b));
  typedef struct {int k; logic busy; logic done; logic pass; logic fail; logic [15:0] cnt;} vec_t;
  vec_t tbl[6];
  logic [1:0] gold [16];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at E%0d: got %0h expected %0h", name, e, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    e++;
  endtask
  task automatic upto(input int k);
    while (e < k) tick();
  endtask
  task automatic go_a();
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    e = 0;
  endtask
  task automatic chk_eq_end();
    upto(32);
    chk("eq_done_E32", done_a, 0);
    upto(33);
    chk("eq_done_E33", done_a, 1);
    chk("eq_pass_E33", pass_a, 1);
    chk("eq_busy_E33", busy_a, 0);
  endtask
  initial begin
    logic [31:0] l;
    l = 32'h1;
    for (int i = 0; i < 16; i++) begin
      gold[i] = l[1:0];
      l = {1'b0, l[31:1]} ^ (l[0] ? 32'h80200003 : 32'h0);
    end
    tbl[0] = '{0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[1] = '{1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[2] = '{20, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[3] = '{32, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[4] = '{33, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0};
    tbl[5] = '{40, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", {busy_a, done_a, pass_a, fail_a, cnt_a, ffi_a, stim_a}, 0);
    rst = 1'b0;
    tick();
    go_a();
    chk("eq_stim_E0", stim_a, 2'b01);
    for (int i = 0; i < 6; i++) begin
      upto(tbl[i].k);
      chk($sformatf("eq_busy_k%0d", tbl[i].k), busy_a, tbl[i].busy);
      chk($sformatf("eq_done_k%0d", tbl[i].k), done_a, tbl[i].done);
      chk($sformatf("eq_pass_k%0d", tbl[i].k), pass_a, tbl[i].pass);
      chk($sformatf("eq_fail_k%0d", tbl[i].k), fail_a, tbl[i].fail);
      chk($sformatf("eq_cnt_k%0d", tbl[i].k), cnt_a, tbl[i].cnt);
    end
    go_a();
    upto(3);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("busy_start_stim_E4", stim_a, gold[2]);
    tick();
    chk("busy_start_stim_E5", stim_a, gold[2]);
    chk_eq_end();
    go_a();
    upto(5);
    rst = 1'b1;
    #1;
    chk("midrst_zero", {busy_a, done_a, pass_a, fail_a, cnt_a, ffi_a, stim_a}, 0);
    rst = 1'b0;
    upto(7);
    go_a();
    chk("rerun_stim_E0", stim_a, 2'b01);
    chk_eq_end();
    mode = 1'b1;
    go_a();
    upto(2);
    chk("ab_done_E2", done_a, 0);
    chk("ab_fail_E2", fail_a, 0);
    upto(3);
    chk("ab_fail_E3", fail_a, 1);
    chk("ab_cnt_E3", cnt_a, 1);
    chk("ab_ffi_E3", ffi_a, 0);
    chk("ab_ffd_E3", ffd_a, 0);
    chk("ab_ffr_E3", ffr_a, 1);
    chk("ab_pass_E3", pass_a, 0);
`ifdef CONTINUE_ON_FAIL_EN
    chk("ab_done_E3", done_a, 0);
    chk("ab_busy_E3", busy_a, 1);
    upto(32);
    chk("cont_done_E32", done_a, 0);
    upto(33);
    chk("cont_done_E33", done_a, 1);
    chk("cont_pass_E33", pass_a, 0);
    chk("cont_cnt_E33", cnt_a, 16);
    chk("cont_ffi_E33", ffi_a, 0);
`else
    chk("ab_done_E3", done_a, 1);
    chk("ab_busy_E3", busy_a, 0);
    chk("ab_stim_E3", stim_a, gold[1]);
    upto(10);
    chk("ab_stim_E10", stim_a, gold[1]);
    chk("ab_cnt_E10", cnt_a, 1);
    chk("ab_done_E10", done_a, 1);
`endif
    mode = 1'b0;
    tick();
    tick();
    go_a();
    chk("clr_fail_E0", fail_a, 0);
    chk("clr_cnt_E0", cnt_a, 0);
    chk("clr_done_E0", done_a, 0);
    chk_eq_end();
    start_b = 1'b1;
    @(posedge clk);
    #1;
    start_b = 1'b0;
    e = 0;
    for (int k = 0; k < 48; k++) begin
      upto(k);
      chk($sformatf("stim_b_k%0d", k), stim_b, gold[k/3]);
    end
    upto(47);
    chk("b_done_E47", done_b, 0);
    upto(48);
    chk("b_done_E48", done_b, 1);
    chk("b_pass_E48", pass_b, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
